mem_wb_load_stage: RTL

MEM_WB_LOAD_STAGE -- requirements
Module: mem_wb_load_stage

---
 rtl/mem_wb_load_stage.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_wb_load_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_load_stage
//  Description : MEM->WB pipeline register. Extracts and extends load data in
//                M, selects the write-back value, detects misaligned loads and
//                registers the result into the W stage. Supports stall, flush
//                and synchronous reset.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_wb_load_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic [31:0] m_dm_out,
    input  logic [31:0] m_addr,
    input  logic [2:0]  m_load_op,
    input  logic [31:0] m_alu_res,
    input  logic [1:0]  m_wd_sel,
    input  logic        m_regwrite,
    input  logic [4:0]  m_rd,
    output logic        w_valid,
    output logic        w_regwrite,
    output logic [4:0]  w_rd,
    output logic [31:0] w_wdata,
    output logic [31:0] w_pc,
    output logic        w_misalign,
    output logic        w_fwd_en
);

    // Load operation encodings
    localparam logic [2:0]  c_LD_LW  = 3'b001;
    localparam logic [2:0]  c_LD_LB  = 3'b010;
    localparam logic [2:0]  c_LD_LBU = 3'b011;
    localparam logic [2:0]  c_LD_LH  = 3'b100;
    localparam logic [2:0]  c_LD_LHU = 3'b101;

    // Write-data source encodings (11 aliases ALU)
    localparam logic [1:0]  c_WD_MEM  = 2'b01;
    localparam logic [1:0]  c_WD_LINK = 2'b10;

    localparam logic [31:0] c_RESET_PC = 32'h0000_3000;

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic        w_misalign_raw;
    logic [31:0] w_wdata_next;
    logic        w_regwrite_next;
    logic        w_misalign_next;

    logic        r_valid;
    logic        r_regwrite;
    logic [4:0]  r_rd;
    logic [31:0] r_wdata;
    logic [31:0] r_pc;
    logic        r_misalign;

    // Byte/half lane selection from the low address bits
    always_comb begin
        w_byte = m_dm_out[7:0];
        case (m_addr[1:0])
            2'b00:   w_byte = m_dm_out[7:0];
            2'b01:   w_byte = m_dm_out[15:8];
            2'b10:   w_byte = m_dm_out[23:16];
            default: w_byte = m_dm_out[31:24];
        endcase
        w_half = m_addr[1] ? m_dm_out[31:16] : m_dm_out[15:0];
    end

    // Load extension and misalignment detection; unknown ops pass the raw word
    always_comb begin
        w_load_data    = m_dm_out;
        w_misalign_raw = 1'b0;
        case (m_load_op)
            c_LD_LW: begin
                w_load_data    = m_dm_out;
                w_misalign_raw = (m_addr[1:0] != 2'b00);
            end
            c_LD_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_LD_LBU: w_load_data = {24'h0, w_byte};
            c_LD_LH: begin
                w_load_data    = {{16{w_half[15]}}, w_half};
                w_misalign_raw = m_addr[0];
            end
            c_LD_LHU: begin
                w_load_data    = {16'h0, w_half};
                w_misalign_raw = m_addr[0];
            end
            default: begin
                w_load_data    = m_dm_out;
                w_misalign_raw = 1'b0;
            end
        endcase
    end

    // Write-back value mux and register-write qualification
    always_comb begin
        case (m_wd_sel)
            c_WD_MEM:  w_wdata_next = w_load_data;
            c_WD_LINK: w_wdata_next = m_pc + 32'd8;
            default:   w_wdata_next = m_alu_res;
        endcase
        w_misalign_next = m_valid & w_misalign_raw;
        w_regwrite_next = m_valid & m_regwrite & (m_rd != 5'd0) & ~w_misalign_raw;
    end

    // W-stage register: reset > flush > stall > capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_misalign <= 1'b0;
            r_rd       <= 5'd0;
            r_wdata    <= 32'd0;
            r_pc       <= c_RESET_PC;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_misalign <= 1'b0;
            r_rd       <= 5'd0;
            r_wdata    <= 32'd0;
            r_pc       <= m_pc;
        end else if (!stall) begin
            r_valid    <= m_valid;
            r_regwrite <= w_regwrite_next;
            r_misalign <= w_misalign_next;
            r_rd       <= m_rd;
            r_wdata    <= w_wdata_next;
            r_pc       <= m_pc;
        end
    end

    assign w_valid    = r_valid;
    assign w_regwrite = r_regwrite;
    assign w_rd       = r_rd;
    assign w_wdata    = r_wdata;
    assign w_pc       = r_pc;
    assign w_misalign = r_misalign;
    assign w_fwd_en   = r_regwrite;

endmodule
`default_nettype wire
